decode_pipe: RTL
================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, width of all PC values.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of register, result and immediate values.
REQ-003 SHALL have parameter REG_COUNT, default 32, number of architectural registers; legal values are 32 (RV32I) and 16 (RV32E).
REQ-004 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have stall_d  input  1  hold the D/E register.
REQ-007 SHALL have flush_d  input  1  load a bubble into the D/E register.
REQ-008 SHALL have valid_f  input  1  instr_f holds a real instruction.
REQ-009 SHALL have instr_f  input  32  fetched instruction.
REQ-010 SHALL have pc_f, pc_plus4_f  input  ADDRESS_WIDTH each  PC and PC+4 of instr_f.
REQ-011 SHALL have reg_write_w  input  1  writeback enable.
REQ-012 SHALL have rd_w  input  5  writeback destination index.
REQ-013 SHALL have result_w  input  DATA_WIDTH  writeback data.
REQ-014 SHALL have ctrl_e  output  17  registered controls, packed MSB to LSB: reg_write, res_src[1:0], mem_write, jump, branch, alu_control[4:0], alu_src_a, alu_src_b, adder_src, funct3[2:0].
REQ-015 SHALL have rd1_e, rd2_e  output  DATA_WIDTH each  registered operands for rs1/rs2.
REQ-016 SHALL have imm_val_e  output  DATA_WIDTH  registered extended immediate.
REQ-017 SHALL have pc_e, pc_plus4_e  output  ADDRESS_WIDTH each  registered PC and PC+4.
REQ-018 SHALL have rs1_e, rs2_e, rd_e  output  5 each  registered instr[19:15], [24:20], [11:7].
REQ-019 SHALL have valid_e  output  1  D/E register holds a real instruction.
REQ-020 SHALL have illegal_e  output  1  registered instruction is illegal.

Function
REQ-021 SHALL decode controls and immediate combinationally from instr_f using the existing control_unit and imm_ext blocks.
REQ-022 SHALL contain REG_COUNT x DATA_WIDTH registers; x0 reads 0 always.
REQ-023 SHALL write result_w to rd_w on the clock edge when reg_write_w=1, rd_w!=0, rd_w<REG_COUNT and rst=0; otherwise no write; writes proceed regardless of stall_d/flush_d.
REQ-024 SHALL bypass: if reg_write_w=1, rd_w!=0 and rd_w equals the read index, the read returns result_w in the same cycle (write-through).
REQ-025 SHALL flag illegal when opcode not in {0x03,0x13,0x17,0x23,0x33,0x37,0x63,0x67,0x6F}, or REG_COUNT=16 and bit 4 of rs1/rs2/rd is set.
REQ-026 SHALL, when valid_f=0 or illegal, force reg_write, mem_write, jump, branch to 0 in the captured ctrl_e; all other fields captured as decoded.
REQ-027 SHALL update the D/E register with priority rst > flush_d > stall_d > capture; latency instr_f to outputs is one cycle.
REQ-028 SHALL on flush_d (also when stall_d=1) load all outputs with 0, including valid_e and illegal_e.
REQ-029 SHALL on stall_d alone hold every output unchanged.
REQ-030 SHALL on capture load valid_e=valid_f and illegal_e=valid_f AND illegal.

Reset
REQ-031 SHALL on rst=1 at a clock edge set every output to 0 and every register-file entry to 0; writeback in that cycle is discarded.
REQ-032 SHALL, when rst deasserts, capture normally on the first following edge.

Verification
REQ-033 SHALL check: instr_f=0x00500093 (addi x1,x0,5), pc_f=0x100, valid_f=1 -> next cycle valid_e=1, rd_e=1, imm_val_e=5, rd1_e=0, pc_e=0x100, pc_plus4_e=0x104, reg_write bit=1.
REQ-034 SHALL check: reg_write_w=1, rd_w=2, result_w=0xDEADBEEF in same cycle as instr_f=0x000101B3 (add x3,x2,x0) -> rd1_e=0xDEADBEEF; x2 reads 0xDEADBEEF thereafter.
REQ-035 SHALL check: reg_write_w=1, rd_w=0, result_w=7, then read x0 -> rd1_e=0.
REQ-036 SHALL check: stall_d=1 for 3 cycles -> outputs frozen; stall_d=1 with flush_d=1 -> all outputs 0, valid_e=0.
REQ-037 SHALL check: REG_COUNT=16, instr_f=0x00088133 (add x2,x17,x0) -> illegal_e=1, reg_write bit=0; instr_f opcode 0x7F -> illegal_e=1 at either REG_COUNT.
REQ-038 SHALL check: rst=1 mid-stream after x5=0x55 written -> all outputs 0, next read of x5 returns 0.

Source files
------------

// File: rtl/decode_pipe_if.sv
// Decode-stage bus: fetch-side inputs, writeback port and D/E register outputs.
// The master drives fetch/writeback; the slave (decode_pipe) drives the E side.
interface decode_pipe_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     stall_d;
  logic                     flush_d;
  logic                     valid_f;
  logic [31:0]              instr_f;
  logic [ADDRESS_WIDTH-1:0] pc_f;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
  logic                     reg_write_w;
  logic [4:0]               rd_w;
  logic [DATA_WIDTH-1:0]    result_w;

  logic [16:0]              ctrl_e;
  logic [DATA_WIDTH-1:0]    rd1_e;
  logic [DATA_WIDTH-1:0]    rd2_e;
  logic [DATA_WIDTH-1:0]    imm_val_e;
  logic [ADDRESS_WIDTH-1:0] pc_e;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_e;
  logic [4:0]               rs1_e;
  logic [4:0]               rs2_e;
  logic [4:0]               rd_e;
  logic                     valid_e;
  logic                     illegal_e;

  modport master (
    output stall_d, flush_d, valid_f, instr_f,
    output pc_f, pc_plus4_f,
    output reg_write_w, rd_w, result_w,
    input  ctrl_e, rd1_e, rd2_e, imm_val_e,
    input  pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
    input  valid_e, illegal_e
  );

  modport slave (
    input  stall_d, flush_d, valid_f, instr_f,
    input  pc_f, pc_plus4_f,
    input  reg_write_w, rd_w, result_w,
    output ctrl_e, rd1_e, rd2_e, imm_val_e,
    output pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
    output valid_e, illegal_e
  );
endinterface

// File: rtl/decode_pipe.sv
// RV32I/E decode stage: control decode, immediate extend, register file
// with write-through bypass, and the D/E pipeline register.
module control_unit #(
  parameter int REG_COUNT = 32
) (
  input  logic [31:0] instr,
  output logic [16:0] ctrl,
  output logic        illegal
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       rw, mw, jmp, br;
  logic [1:0] res;
  logic [4:0] alu;
  logic       sa, sb, ad;
  logic       legal;
  logic       e_bad;

  assign op = instr[6:0];
  assign f3 = instr[14:12];

  always_comb begin
    rw    = 1'b0;
    res   = 2'b00;
    mw    = 1'b0;
    jmp   = 1'b0;
    br    = 1'b0;
    alu   = 5'd0;
    sa    = 1'b0;
    sb    = 1'b0;
    ad    = 1'b0;
    legal = 1'b1;
    unique case (1'b1)
      (op == 7'h03): begin
        rw  = 1'b1;
        res = 2'b01;
        sb  = 1'b1;
      end
      (op == 7'h13): begin
        rw  = 1'b1;
        sb  = 1'b1;
        alu = {1'b0, (f3 == 3'b101) & instr[30], f3};
      end
      (op == 7'h17): begin
        rw = 1'b1;
        sa = 1'b1;
        sb = 1'b1;
      end
      (op == 7'h23): begin
        mw = 1'b1;
        sb = 1'b1;
      end
      (op == 7'h33): begin
        rw  = 1'b1;
        alu = {1'b0, instr[30], f3};
      end
      (op == 7'h37): begin
        rw  = 1'b1;
        sb  = 1'b1;
        alu = 5'h1f;
      end
      (op == 7'h63): begin
        br  = 1'b1;
        alu = {2'b10, f3};
      end
      (op == 7'h67): begin
        rw  = 1'b1;
        res = 2'b10;
        jmp = 1'b1;
        sb  = 1'b1;
        ad  = 1'b1;
      end
      (op == 7'h6f): begin
        rw  = 1'b1;
        res = 2'b10;
        jmp = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // RV32E only has x0..x15: any register field with bit 4 set is illegal
  assign e_bad   = (REG_COUNT == 16) &&
                   (instr[19] | instr[24] | instr[11]);
  assign illegal = !legal || e_bad;
  assign ctrl    = {rw, res, mw, jmp, br, alu, sa, sb, ad, f3};
endmodule

module imm_ext (
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  logic [6:0] op;
  logic       s;

  assign op = instr[6:0];
  assign s  = instr[31];

  always_comb begin
    imm = 32'd0;
    unique case (1'b1)
      (op == 7'h03),
      (op == 7'h13),
      (op == 7'h67):
        imm = {{20{s}}, instr[31:20]};
      (op == 7'h23):
        imm = {{20{s}}, instr[31:25], instr[11:7]};
      (op == 7'h63):
        imm = {{19{s}}, s, instr[7], instr[30:25],
               instr[11:8], 1'b0};
      (op == 7'h17),
      (op == 7'h37):
        imm = {instr[31:12], 12'd0};
      (op == 7'h6f):
        imm = {{11{s}}, s, instr[19:12], instr[20],
               instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end
endmodule

module decode_pipe #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_COUNT     = 32
) (
  input logic          clk,
  input logic          rst,
  decode_pipe_if.slave bus
);
  localparam int RIW = $clog2(REG_COUNT);

  typedef struct packed {
    logic [16:0]              ctrl;
    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;
    logic [DATA_WIDTH-1:0]    imm;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc4;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic                     valid;
    logic                     illegal;
  } de_t;

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [16:0]           ctrl;
  logic                  illegal;
  logic [31:0]           imm32;
  logic [4:0]            rs1, rs2;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic                  we, wb_hot;
  de_t                   de_d, de_q;

  control_unit #(.REG_COUNT(REG_COUNT)) u_ctrl (
    .instr   (bus.instr_f),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  imm_ext u_imm (
    .instr (bus.instr_f),
    .imm   (imm32)
  );

  assign rs1    = bus.instr_f[19:15];
  assign rs2    = bus.instr_f[24:20];
  assign wb_hot = bus.reg_write_w && (bus.rd_w != 5'd0);
  assign we     = wb_hot && (int'(bus.rd_w) < REG_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < REG_COUNT; k++)
        regs[k] <= '0;
    end else if (we) begin
      regs[bus.rd_w[RIW-1:0]] <= bus.result_w;
    end
  end

  // write-through: a same-cycle writeback wins over the stored value
  always_comb begin
    rd1 = '0;
    if (rs1 != 5'd0) begin
      if (wb_hot && bus.rd_w == rs1)
        rd1 = bus.result_w;
      else if (int'(rs1) < REG_COUNT)
        rd1 = regs[rs1[RIW-1:0]];
    end
  end

  always_comb begin
    rd2 = '0;
    if (rs2 != 5'd0) begin
      if (wb_hot && bus.rd_w == rs2)
        rd2 = bus.result_w;
      else if (int'(rs2) < REG_COUNT)
        rd2 = regs[rs2[RIW-1:0]];
    end
  end

  always_comb begin
    de_d         = '0;
    de_d.ctrl    = ctrl;
    if (!bus.valid_f || illegal) begin
      de_d.ctrl[16]    = 1'b0;
      de_d.ctrl[13:11] = 3'b000;
    end
    de_d.rd1     = rd1;
    de_d.rd2     = rd2;
    de_d.imm     = DATA_WIDTH'($signed(imm32));
    de_d.pc      = bus.pc_f;
    de_d.pc4     = bus.pc_plus4_f;
    de_d.rs1     = rs1;
    de_d.rs2     = rs2;
    de_d.rd      = bus.instr_f[11:7];
    de_d.valid   = bus.valid_f;
    de_d.illegal = bus.valid_f && illegal;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_d)
      de_q <= '0;
    else if (!bus.stall_d)
      de_q <= de_d;
  end

  assign bus.ctrl_e     = de_q.ctrl;
  assign bus.rd1_e      = de_q.rd1;
  assign bus.rd2_e      = de_q.rd2;
  assign bus.imm_val_e  = de_q.imm;
  assign bus.pc_e       = de_q.pc;
  assign bus.pc_plus4_e = de_q.pc4;
  assign bus.rs1_e      = de_q.rs1;
  assign bus.rs2_e      = de_q.rs2;
  assign bus.rd_e       = de_q.rd;
  assign bus.valid_e    = de_q.valid;
  assign bus.illegal_e  = de_q.illegal;
endmodule
